// File: rtl/game_gfx_pkg.sv
// Shared graphics definitions for the game datapath: screen geometry,
// colour format, the sprite blitter state encoding and a size clamp helper.
package game_gfx_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int COLOUR_W = 9;

    // Sprite pixels with this colour are never written to the frame buffer.
    localparam logic [COLOUR_W-1:0] TRANSPARENT = 9'h1FF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } blit_state_e;

    // Limit a requested sprite dimension to the largest supported one.
    function automatic logic [5:0] clamp_dim(input logic [5:0] dim, input logic [5:0] max_dim);
        logic [5:0] res;
        if (dim > max_dim) begin
            res = max_dim;
        end else begin
            res = dim;
        end
        return res;
    endfunction

endpackage

// File: rtl/sprite_addr_gen.sv
// Column/row walker for the sprite blitter. Produces the running ROM
// address (ascending, or descending within each row when mirrored) and
// flags the final pixel of the rectangle. Addresses wrap modulo 2^ADDR_W.
module sprite_addr_gen
    import game_gfx_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_load,
    input  logic              i_adv,
    input  logic              i_hflip,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [5:0]        i_w,
    input  logic [5:0]        i_h,
    output logic [ADDR_W-1:0] o_addr,
    output logic [5:0]        o_col,
    output logic [5:0]        o_row,
    output logic              o_last
);

    logic [5:0]        r_col;
    logic [5:0]        r_row;
    logic [5:0]        r_w;
    logic [5:0]        r_h;
    logic              r_flip;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_row_base;

    logic              w_col_end;
    logic [ADDR_W-1:0] w_next_row_base;
    logic [ADDR_W-1:0] w_next_addr;
    logic [ADDR_W-1:0] w_load_addr;

    // Next-address selection: step within a row, or jump to the next row start.
    always_comb begin
        w_col_end       = (r_col == (r_w - 6'd1));
        w_next_row_base = r_row_base + ADDR_W'(r_w);
        w_next_addr     = r_addr;
        if (w_col_end) begin
            if (r_flip) begin
                w_next_addr = w_next_row_base + ADDR_W'(r_w) - ADDR_W'(1'b1);
            end else begin
                w_next_addr = w_next_row_base;
            end
        end else begin
            if (r_flip) begin
                w_next_addr = r_addr - ADDR_W'(1'b1);
            end else begin
                w_next_addr = r_addr + ADDR_W'(1'b1);
            end
        end
        if (i_hflip) begin
            w_load_addr = i_base + ADDR_W'(i_w) - ADDR_W'(1'b1);
        end else begin
            w_load_addr = i_base;
        end
    end

    // Counter and address registers: load on request, step once per pixel.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_col      <= 6'd0;
            r_row      <= 6'd0;
            r_w        <= 6'd0;
            r_h        <= 6'd0;
            r_flip     <= 1'b0;
            r_addr     <= '0;
            r_row_base <= '0;
        end else if (i_load) begin
            r_col      <= 6'd0;
            r_row      <= 6'd0;
            r_w        <= i_w;
            r_h        <= i_h;
            r_flip     <= i_hflip;
            r_addr     <= w_load_addr;
            r_row_base <= i_base;
        end else if (i_adv) begin
            if (w_col_end) begin
                r_col      <= 6'd0;
                r_row      <= r_row + 6'd1;
                r_row_base <= w_next_row_base;
            end else begin
                r_col      <= r_col + 6'd1;
            end
            r_addr <= w_next_addr;
        end
    end

    assign o_addr = r_addr;
    assign o_col  = r_col;
    assign o_row  = r_row;
    assign o_last = w_col_end && (r_row == (r_h - 6'd1));

endmodule

// File: rtl/sprite_blit_engine.sv
// Rectangular sprite blitter feeding the 160x120 VGA adapter. Reads sprite
// pixels from a synchronous ROM, emits one pixel per clock, suppresses
// transparent and off-screen pixels and pulses done when finished.
// Optional macro SPRITE_HFLIP_EN adds an hflip input that mirrors each row.
module sprite_blit_engine
    import game_gfx_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int MAX_W  = 32,
    parameter int MAX_H  = 32
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [7:0]          x_org,
    input  logic [6:0]          y_org,
    input  logic [5:0]          w_in,
    input  logic [5:0]          h_in,
`ifdef SPRITE_HFLIP_EN
    input  logic                hflip,
`endif
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [COLOUR_W-1:0] rom_data,
    output logic [7:0]          x,
    output logic [6:0]          y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic                busy,
    output logic                done
);

    blit_state_e r_state;
    blit_state_e w_next_state;

    logic [7:0]          r_x_org;
    logic [6:0]          r_y_org;
    logic                r_vld;
    logic [5:0]          r_col_d;
    logic [5:0]          r_row_d;
    logic [7:0]          r_x;
    logic [6:0]          r_y;
    logic [COLOUR_W-1:0] r_colour;
    logic                r_plot;
    logic                r_busy;
    logic                r_done;

    logic [5:0]          w_w;
    logic [5:0]          w_h;
    logic                w_hflip;
    logic                w_accept;
    logic                w_zero;
    logic                w_load;
    logic                w_adv;
    logic                w_last;
    logic [5:0]          w_col;
    logic [5:0]          w_row;
    logic [ADDR_W-1:0]   w_addr;
    logic [8:0]          w_x_sum;
    logic [7:0]          w_y_sum;
    logic                w_plot_next;

`ifdef SPRITE_HFLIP_EN
    assign w_hflip = hflip;
`else
    assign w_hflip = 1'b0;
`endif

    assign w_w      = clamp_dim(w_in, 6'(MAX_W));
    assign w_h      = clamp_dim(h_in, 6'(MAX_H));
    assign w_zero   = (w_w == 6'd0) || (w_h == 6'd0);
    assign w_accept = (r_state == IDLE) && start;
    assign w_load   = w_accept && !w_zero;
    assign w_adv    = (r_state == RUN) && !w_last;

    sprite_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk     (clk),
        .resetn  (resetn),
        .i_load  (w_load),
        .i_adv   (w_adv),
        .i_hflip (w_hflip),
        .i_base  (base_addr),
        .i_w     (w_w),
        .i_h     (w_h),
        .o_addr  (w_addr),
        .o_col   (w_col),
        .o_row   (w_row),
        .o_last  (w_last)
    );

    // Blit state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: accept a request, walk the rectangle, drain, report.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (w_zero) begin
                        w_next_state = DONE;
                    end else begin
                        w_next_state = RUN;
                    end
                end else begin
                    w_next_state = IDLE;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_next_state = FLUSH;
                end else begin
                    w_next_state = RUN;
                end
            end
            FLUSH:   w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Latch the sprite origin when a request is accepted.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_x_org <= 8'd0;
            r_y_org <= 7'd0;
        end else if (w_accept) begin
            r_x_org <= x_org;
            r_y_org <= y_org;
        end
    end

    // Delay valid/column/row by one cycle to line up with the ROM read data.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_vld   <= 1'b0;
            r_col_d <= 6'd0;
            r_row_d <= 6'd0;
        end else begin
            r_vld   <= (r_state == RUN);
            r_col_d <= w_col;
            r_row_d <= w_row;
        end
    end

    // Screen position and visibility of the pixel whose colour is on rom_data.
    always_comb begin
        w_x_sum     = {1'b0, r_x_org} + {3'b000, r_col_d};
        w_y_sum     = {1'b0, r_y_org} + {2'b00, r_row_d};
        w_plot_next = r_vld
                   && (rom_data != TRANSPARENT)
                   && (w_x_sum < 9'(SCREEN_W))
                   && (w_y_sum < 8'(SCREEN_H));
    end

    // Registered pixel outputs towards the VGA adapter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_x      <= 8'd0;
            r_y      <= 7'd0;
            r_colour <= '0;
            r_plot   <= 1'b0;
        end else begin
            r_plot <= w_plot_next;
            if (r_vld) begin
                r_x      <= w_x_sum[7:0];
                r_y      <= w_y_sum[6:0];
                r_colour <= rom_data;
            end
        end
    end

    // Registered status: busy while walking/draining, done one cycle after DONE.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (r_state == RUN) || (r_state == FLUSH);
            r_done <= (r_state == DONE);
        end
    end

    assign rom_addr = w_addr;
    assign x        = r_x;
    assign y        = r_y;
    assign colour   = r_colour;
    assign plot     = r_plot;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_sprite_blit_engine.sv
// Self-checking bench for sprite_blit_engine: a synchronous ROM model, a
// per-request pixel model (row-major walk, clipping, transparency) and
// literal pixel counts / address sequences that pin the model.
module tb_sprite_blit_engine;

    logic        clk;
    logic        resetn;
    logic        start;
    logic [13:0] base_addr;
    logic [7:0]  x_org;
    logic [6:0]  y_org;
    logic [5:0]  w_in;
    logic [5:0]  h_in;
    logic        hflip;
    logic [13:0] rom_addr;
    logic [8:0]  rom_data;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [8:0]  colour;
    logic        plot;
    logic        busy;
    logic        done;

    logic [8:0]  rom [0:16383];
    logic [13:0] exp_last_addr;
    int          errors;
    int          checks;
    int          cur_t;
    int          plot_seen;
    int          addr_log [0:7];

    sprite_blit_engine dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .base_addr (base_addr),
        .x_org     (x_org),
        .y_org     (y_org),
        .w_in      (w_in),
        .h_in      (h_in),
`ifdef SPRITE_HFLIP_EN
        .hflip     (hflip),
`endif
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .x         (x),
        .y         (y),
        .colour    (colour),
        .plot      (plot),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s t=%0d actual=%0d expected=%0d", nm, cur_t, act, exp);
        end
    endtask

    function automatic int blit_addr(input int base, input int w, input bit flip, input int k);
        int r;
        int c;
        r = k / w;
        c = k % w;
        if (flip) return (base + r * w + (w - 1 - c)) & 16383;
        return (base + k) & 16383;
    endfunction

    // One request from acceptance to the done pulse; called at a negedge.
    task automatic do_blit(input int base, input int xo, input int yo, input int wi, input int hi,
                           input bit flip, input bit hold, input int exp_plots);
        int w, h, n, tend, bound, k, a, xs, ys, c, r;
        bit p;
        w = (wi > 32) ? 32 : wi;
        h = (hi > 32) ? 32 : hi;
        n = w * h;
        tend  = (n == 0) ? 1 : n + 2;
        bound = hold ? tend + 1 : tend;
        base_addr = 14'(base);
        x_org = 8'(xo);
        y_org = 7'(yo);
        w_in  = 6'(wi);
        h_in  = 6'(hi);
        hflip = flip;
        start = 1'b1;
        plot_seen = 0;
        @(posedge clk);
        @(negedge clk);
        if (!hold) start = 1'b0;
        base_addr = ~base_addr;
        x_org = ~x_org;
        y_org = ~y_org;
        w_in  = 6'd7;
        h_in  = 6'd7;
        hflip = ~hflip;
        for (int t = 0; t <= bound; t++) begin
            if (t > 0) @(negedge clk);
            cur_t = t;
            chk("busy", int'(busy), int'(n > 0 && t >= 1 && t <= n + 1));
            chk("done", int'(done), int'(t == tend));
            if (n > 0) begin
                chk("rom_addr", int'(rom_addr), blit_addr(base, w, flip, (t < n) ? t : n - 1));
                if (t < n && t < 8) addr_log[t] = int'(rom_addr);
            end else begin
                chk("rom_addr", int'(rom_addr), int'(exp_last_addr));
            end
            k = t - 2;
            if (n > 0 && k >= 0 && k < n) begin
                r  = k / w;
                c  = k % w;
                a  = blit_addr(base, w, flip, k);
                xs = xo + c;
                ys = yo + r;
                p  = (rom[a] != 9'h1FF) && (xs < 160) && (ys < 120);
                chk("plot", int'(plot), int'(p));
                chk("x", int'(x), xs & 255);
                chk("y", int'(y), ys & 127);
                chk("colour", int'(colour), int'(rom[a]));
            end else begin
                chk("plot_idle", int'(plot), 0);
            end
            if (plot) plot_seen++;
            if (hold && t == n + 1) start = 1'b0;
        end
        if (n > 0) exp_last_addr = 14'(blit_addr(base, w, flip, n - 1));
        cur_t = -1;
        chk("plot_count", plot_seen, exp_plots);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_x"}, int'(x), 0);
        chk({nm, "_y"}, int'(y), 0);
        chk({nm, "_colour"}, int'(colour), 0);
        chk({nm, "_rom_addr"}, int'(rom_addr), 0);
        chk({nm, "_plot"}, int'(plot), 0);
        chk({nm, "_busy"}, int'(busy), 0);
        chk({nm, "_done"}, int'(done), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0d actual=timeout expected=finish", cur_t);
        $fatal(1, "watchdog expired");
    end

    initial begin
        errors = 0;
        checks = 0;
        cur_t  = -1;
        exp_last_addr = 14'd0;
        for (int i = 0; i < 16384; i++) rom[i] = 9'(i);
        resetn = 1'b0;
        start = 1'b0;
        base_addr = 14'd0;
        x_org = 8'd0;
        y_org = 7'd0;
        w_in = 6'd0;
        h_in = 6'd0;
        hflip = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        resetn = 1'b1;
        @(negedge clk);

        // 4x3 opaque sprite, colours 0..11
        do_blit(0, 10, 20, 4, 3, 1'b0, 1'b0, 12);
        // Same sprite with one transparent pixel at (11,21); back-to-back start
        rom[5] = 9'h1FF;
        do_blit(0, 10, 20, 4, 3, 1'b0, 1'b0, 11);
        rom[5] = 9'd5;
        // Bottom-right clipping: only a 4x4 corner is visible
        do_blit(200, 156, 116, 8, 8, 1'b0, 1'b0, 16);
        // Zero-width request: no ROM traffic, done after edge 1
        do_blit(500, 3, 3, 0, 5, 1'b0, 1'b0, 0);
        // Address wrap at the top of ROM; ROM[16383] is transparent
        do_blit(16380, 0, 0, 3, 2, 1'b0, 1'b0, 5);
        chk("wrap_addr4", addr_log[4], 0);
        chk("wrap_addr5", addr_log[5], 1);
        // Width clamp to 32; ROM[1023] is transparent
        do_blit(1000, 0, 0, 40, 1, 1'b0, 1'b0, 31);
        // Height clamp to 32 with bottom clipping at y=120
        do_blit(2000, 0, 100, 1, 40, 1'b0, 1'b0, 20);

        // Reset mid-RUN aborts without a done pulse
        base_addr = 14'd0;
        x_org = 8'd10;
        y_org = 7'd20;
        w_in = 6'd4;
        h_in = 6'd3;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b0;
        #1;
        chk_all_zero("midreset");
        repeat (2) @(negedge clk);
        chk("midreset_done", int'(done), 0);
        chk("midreset_busy", int'(busy), 0);
        resetn = 1'b1;
        exp_last_addr = 14'd0;
        @(negedge clk);
        // Start held high for the whole request: re-requests are ignored
        do_blit(300, 50, 60, 5, 2, 1'b0, 1'b1, 10);

`ifdef SPRITE_HFLIP_EN
        // Mirrored 3x2 sprite at base 100
        do_blit(100, 0, 0, 3, 2, 1'b1, 1'b0, 6);
        chk("flip_a0", addr_log[0], 102);
        chk("flip_a1", addr_log[1], 101);
        chk("flip_a2", addr_log[2], 100);
        chk("flip_a3", addr_log[3], 105);
        chk("flip_a4", addr_log[4], 104);
        chk("flip_a5", addr_log[5], 103);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
